// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: handshake FSM states shared by the tx and rx sides
// of the four-phase req/ack crossing.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } hs_state_e;

endpackage

// File: rtl/cdc_hs_tx_ffchain.sv
// FFchain: DEPTH-stage flop chain with enable, used as a
// multi-flop synchronizer; all stages clear on reset.
module FFchain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (ena_i) begin
            stage[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q_o = stage[DEPTH-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a four-phase req/ack crossing.
// Optional per-phase timeout: define CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             error_o,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i
);

    localparam int WW = $clog2(DEPTH + 1);

    hs_state_e     state;
    logic          ack_s;
    logic [WW-1:0] warm;
    logic          expire;
    logic          drop;

    FFchain #(
        .WIDTH(1),
        .DEPTH(DEPTH)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .ena_i (1'b1),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    // A high ack seen during reset blocks acceptance until the chain
    // holds real samples, so a stale ack cannot look like idle.
    assign ready_o = rst_ni && (state == IDLE) && !ack_s
                  && (warm == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            req_o  <= 1'b0;
            data_o <= '0;
            done_o <= 1'b0;
            warm   <= ack_i ? WW'(DEPTH) : '0;
        end else begin
            done_o <= 1'b0;
            if (warm != '0) warm <= warm - WW'(1);
            unique case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        data_o <= data_i;
                        req_o  <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s || expire) begin
                        req_o <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!ack_s) begin
                        state  <= IDLE;
                        done_o <= !drop;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = (cnt == LAST);

    // Awaited ack transitions are checked first so they beat a
    // coincident expiry; the WAIT count saturates to pulse once.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            drop    <= 1'b0;
            error_o <= 1'b0;
        end else begin
            error_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt  <= '0;
                    drop <= 1'b0;
                end
                REQ: begin
                    if (ack_s) begin
                        cnt <= '0;
                    end else if (expire) begin
                        cnt     <= '0;
                        drop    <= 1'b1;
                        error_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (!ack_s) begin
                        cnt <= '0;
                    end else begin
                        if (expire) error_o <= 1'b1;
                        if (cnt != FULL) cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign drop           = 1'b0;
    assign error_o        = 1'b0;
`endif

endmodule
